// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the asynchronous FIFO pointer controllers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    localparam int DEF_ADDRSIZE    = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_AE_THRESH   = 1;

    // Widest pointer gray2bin can convert; callers zero-extend into this.
    localparam int GRAY_MAXW = 32;

    // Gray-to-binary for a code of 'width' bits held in the low bits of g.
    // Binary bit i is the XOR of all Gray bits at positions >= i, so bits
    // above 'width' are masked off first to keep the conversion exact.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(
        input logic [GRAY_MAXW-1:0] g,
        input int                   width
    );
        logic [GRAY_MAXW-1:0] gm;
        logic [GRAY_MAXW-1:0] b;
        gm = g;
        b  = '0;
        for (int i = 0; i < GRAY_MAXW; i++) begin
            if (i >= width) begin
                gm[i] = 1'b0;
            end
        end
        for (int i = 0; i < GRAY_MAXW; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchronizer bringing a Gray-coded bus into the local clock domain.
// Latency: STAGES cycles from i_d to o_q, no logic between stages.
// Backpressure: none; samples every cycle.
//
// Ports: i_clk clock, i_rst synchronous active-high reset (clears all stages),
//        i_d foreign-domain input, o_q synchronized output.
module sync_nff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer, empty/almost-empty flag and occupancy logic of an async FIFO.
// Latency: rd_wptr change seen on flags/count at edge SYNC_STAGES+1; reads take effect next edge.
// Backpressure: reads accepted one per cycle while rempty=0; rinc while empty is ignored.
//
// Ports: rclk clock; rrst synchronous active-high reset; rinc read request;
//        rd_wptr Gray write pointer (unsynchronized); raddr binary memory address;
//        rptr Gray read pointer to write domain; rempty / ralmost_empty flags;
//        rcount words available; runderflow sticky flag (only with RD_UNDERFLOW_EN).
// Build option: define RD_UNDERFLOW_EN to add the runderflow port and logic.
module rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = DEF_ADDRSIZE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int AE_THRESH   = DEF_AE_THRESH
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rd_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rcount
`ifdef RD_UNDERFLOW_EN
    ,
    output logic                runderflow
`endif
);

    localparam int              PW    = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] LP_AE = PW'(AE_THRESH);

    logic [ADDRSIZE:0] w_wptr_sync;
    logic [ADDRSIZE:0] w_wbin_sync;
    logic              w_rd_en;
    logic [ADDRSIZE:0] w_rbinnext;
    logic [ADDRSIZE:0] w_rgraynext;
    logic [ADDRSIZE:0] w_diff;
    logic [ADDRSIZE:0] r_bin;

    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .i_clk (rclk),
        .i_rst (rrst),
        .i_d   (rd_wptr),
        .o_q   (w_wptr_sync)
    );

    assign w_wbin_sync = PW'(gray2bin(GRAY_MAXW'(w_wptr_sync), PW));

    // A read while empty is dropped here, so the pointer never passes the writer.
    assign w_rd_en     = rinc & ~rempty;
    assign w_rbinnext  = r_bin + PW'(w_rd_en);
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

    // Modular difference: the extra wrap bit keeps full (2**ADDRSIZE) distinct from empty.
    assign w_diff      = w_wbin_sync - w_rbinnext;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_bin         <= '0;
            raddr         <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rcount        <= '0;
        end else begin
            r_bin         <= w_rbinnext;
            raddr         <= w_rbinnext[ADDRSIZE-1:0];
            rptr          <= w_rgraynext;
            // Flags look at the post-read pointer so the last read clears nothing late.
            rempty        <= (w_rgraynext == w_wptr_sync);
            ralmost_empty <= (w_diff <= LP_AE);
            rcount        <= w_diff;
        end
    end

`ifdef RD_UNDERFLOW_EN
    always_ff @(posedge rclk) begin
        if (rrst) begin
            runderflow <= 1'b0;
        end else if (rinc && rempty) begin
            runderflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Self-checking bench for rd_ptr_ctrl: directed reset/latency/burst/wrap/underflow
// and mid-burst reset steps plus a randomized phase, against a word-count model.
// Latency/backpressure: n/a (testbench).
module tb_rd_ptr_ctrl;

    localparam int AS    = 4;
    localparam int SS    = 2;
    localparam int AE    = 1;
    localparam int DEPTH = 1 << AS;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          rinc = 1'b0;
    logic [AS:0]   rd_wptr = '0;
    logic [AS-1:0] raddr;
    logic [AS:0]   rptr;
    logic          rempty;
    logic          ralmost_empty;
    logic [AS:0]   rcount;
`ifdef RD_UNDERFLOW_EN
    logic          runderflow;
`endif

    rd_ptr_ctrl #(
        .ADDRSIZE    (AS),
        .SYNC_STAGES (SS),
        .AE_THRESH   (AE)
    ) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .rd_wptr       (rd_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rcount        (rcount)
`ifdef RD_UNDERFLOW_EN
        ,
        .runderflow    (runderflow)
`endif
    );

    always #5 rclk = ~rclk;

    // Reference model: words written / read as plain integers.
    int wr_total = 0;
    int rd_total = 0;
    int wq [SS];
    int m_count  = 0;
    bit m_empty  = 1'b1;
    bit m_ae     = 1'b1;
    bit m_uf     = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [AS:0] to_gray(input int n);
        logic [AS:0] b;
        b = (AS+1)'(n % (2*DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic inc, input logic rst);
        int wsync;
        if (rst) begin
            rd_total = 0;
            for (int i = 0; i < SS; i++) wq[i] = 0;
            m_count = 0;
            m_empty = 1'b1;
            m_ae    = 1'b1;
            m_uf    = 1'b0;
        end else begin
            if (inc && m_empty) m_uf = 1'b1;
            if (inc && !m_empty) rd_total++;
            // Writer's progress as visible after the synchronizer delay.
            wsync = wq[SS-1];
            for (int i = SS-1; i > 0; i--) wq[i] = wq[i-1];
            wq[0] = wr_total;
            m_count = wsync - rd_total;
            m_empty = (m_count == 0);
            m_ae    = (m_count <= AE);
        end
    endtask

    task automatic tick(input logic inc, input logic rst);
        rinc    = inc;
        rrst    = rst;
        rd_wptr = to_gray(wr_total);
        @(posedge rclk);
        model_edge(inc, rst);
        #1;
        chk("model_rempty", 32'(rempty), 32'(m_empty));
        chk("model_ralmost_empty", 32'(ralmost_empty), 32'(m_ae));
        chk("model_rcount", 32'(rcount), 32'(m_count));
        chk("model_rptr", 32'(rptr), 32'(to_gray(rd_total)));
        chk("model_raddr", 32'(raddr), 32'(rd_total % DEPTH));
`ifdef RD_UNDERFLOW_EN
        chk("model_runderflow", 32'(runderflow), 32'(m_uf));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < SS; i++) wq[i] = 0;

        // Reset, with random read requests that must be ignored.
        tick(1'($urandom_range(0, 1)), 1'b1);
        tick(1'($urandom_range(0, 1)), 1'b1);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_ralmost_empty", 32'(ralmost_empty), 32'd1);
        chk("rst_rcount", 32'(rcount), 32'd0);
        chk("rst_rptr", 32'(rptr), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);

        // Empty-flag latency: one word appears, flags move on edge 3.
        wr_total = 1;
        tick(1'b0, 1'b0);
        chk("lat_e1_rempty", 32'(rempty), 32'd1);
        tick(1'b0, 1'b0);
        chk("lat_e2_rempty", 32'(rempty), 32'd1);
        tick(1'b0, 1'b0);
        chk("lat_e3_rempty", 32'(rempty), 32'd0);
        chk("lat_e3_rcount", 32'(rcount), 32'd1);
        chk("lat_e3_ralmost_empty", 32'(ralmost_empty), 32'd1);

        // Burst: 16 words written, then 16 back-to-back reads.
        wr_total = 16;
        repeat (3) tick(1'b0, 1'b0);
        chk("burst_full_rcount", 32'(rcount), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("burst_raddr", 32'(raddr), 32'(i));
            tick(1'b1, 1'b0);
        end
        chk("burst_rptr", 32'(rptr), 32'b11000);
        chk("burst_rempty", 32'(rempty), 32'd1);
        chk("burst_rcount", 32'(rcount), 32'd0);

        // Wrap: writer reaches 32 (Gray 00000), FIFO full must not look empty.
        wr_total = 32;
        repeat (3) tick(1'b0, 1'b0);
        chk("wrap_full_rcount", 32'(rcount), 32'd16);
        chk("wrap_full_rempty", 32'(rempty), 32'd0);
        chk("wrap_full_ralmost_empty", 32'(ralmost_empty), 32'd0);
        repeat (DEPTH) tick(1'b1, 1'b0);
        chk("wrap_rptr", 32'(rptr), 32'b00000);
        chk("wrap_rempty", 32'(rempty), 32'd1);

        // Underflow: reads while empty change nothing.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("uf_rptr", 32'(rptr), 32'b00000);
        chk("uf_raddr", 32'(raddr), 32'd0);
`ifdef RD_UNDERFLOW_EN
        chk("uf_flag", 32'(runderflow), 32'd1);
        tick(1'b0, 1'b0);
        chk("uf_sticky", 32'(runderflow), 32'd1);
`endif

        // Randomized traffic; the writer never overfills the FIFO.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) != 0 && (wr_total - rd_total) < DEPTH) wr_total++;
            tick(1'($urandom_range(0, 1)), 1'b0);
        end

        // Settle, drain, then refill to 10 and read 3 to reach 7.
        repeat (3) tick(1'b0, 1'b0);
        for (int k = 0; k < 64 && rempty == 1'b0; k++) tick(1'b1, 1'b0);
        chk("drain_rempty", 32'(rempty), 32'd1);
        wr_total = rd_total + 10;
        repeat (3) tick(1'b0, 1'b0);
        chk("refill_rcount", 32'(rcount), 32'd10);
        repeat (3) tick(1'b1, 1'b0);
        chk("pre_rst_rcount", 32'(rcount), 32'd7);

        // Reset mid-burst with rinc still high.
        wr_total = 0;
        tick(1'b1, 1'b1);
        chk("mid_rst_rempty", 32'(rempty), 32'd1);
        chk("mid_rst_ralmost_empty", 32'(ralmost_empty), 32'd1);
        chk("mid_rst_rcount", 32'(rcount), 32'd0);
        chk("mid_rst_rptr", 32'(rptr), 32'd0);
        chk("mid_rst_raddr", 32'(raddr), 32'd0);
`ifdef RD_UNDERFLOW_EN
        chk("mid_rst_runderflow", 32'(runderflow), 32'd0);
`endif
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("post_rst_rptr", 32'(rptr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_ptr_ctrl.md
RD_PTR_CTRL -- requirements
Module: rd_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: the memory address width, giving a depth of 2**ADDRSIZE.
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (legal values 2..4): the flop count of the rd_wptr synchronizer.
REQ-003 SHALL have parameter AE_THRESH, default 1 (legal values 0..2**ADDRSIZE): the almost-empty level in words.
REQ-004 SHALL have port rclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rrst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rinc, input, 1 bit: read request.
REQ-007 SHALL have port rd_wptr, input, ADDRSIZE+1 bits: the Gray write pointer from the foreign domain, unsynchronized.
REQ-008 SHALL have port raddr, output, ADDRSIZE bits: the binary read address to the memory.
REQ-009 SHALL have port rptr, output, ADDRSIZE+1 bits: the registered Gray read pointer exported to the write domain.
REQ-010 SHALL have port rempty, output, 1 bit: registered empty flag.
REQ-011 SHALL have port ralmost_empty, output, 1 bit: registered almost-empty flag.
REQ-012 SHALL have port rcount, output, ADDRSIZE+1 bits: registered occupancy (words available to read).
REQ-013 SHALL have port runderflow, output, 1 bit, present only when RD_UNDERFLOW_EN is defined: sticky underflow flag.

Function
REQ-014 SHALL pass rd_wptr through SYNC_STAGES flops to form wptr_sync; no logic is permitted between stages.
REQ-015 SHALL compute wbin_sync as the Gray-to-binary conversion of wptr_sync.
REQ-016 SHALL hold an internal binary pointer rbin of ADDRSIZE+1 bits; rbin increments, wrapping modulo 2**(ADDRSIZE+1), only when rinc=1 and rempty=0.
REQ-017 SHALL set rbinnext = rbin + (rinc & ~rempty) and rgraynext = (rbinnext>>1) ^ rbinnext; Gray is derived from the next binary value, not the current one.
REQ-018 SHALL register raddr = rbin[ADDRSIZE-1:0] and rptr <= rgraynext every cycle, so that rptr always equals Gray(rbin).
REQ-019 SHALL register rempty <= (rgraynext == wptr_sync), a full ADDRSIZE+1-bit compare, so the wrap bit distinguishes empty from full.
REQ-020 SHALL register rcount <= (wbin_sync - rbinnext) modulo 2**(ADDRSIZE+1); rcount ranges 0..2**ADDRSIZE.
REQ-021 SHALL register ralmost_empty <= ((wbin_sync - rbinnext) <= AE_THRESH); with AE_THRESH=0 it equals rempty.
REQ-022 SHALL update rempty, rcount and ralmost_empty on rclk edge SYNC_STAGES+1 after a rd_wptr change, where edge 1 is the first edge that samples the new value.
REQ-023 SHALL, when a read of the last word coincides with wptr_sync advancing, evaluate both terms in the same cycle, with no priority between them.
REQ-024 SHALL treat rinc=1 while rempty=1 as a no-op: rbin, raddr and rptr are unchanged.
REQ-025 SHALL allow sustained back-to-back reads at one word per cycle while rempty=0.

Reset
REQ-026 SHALL, on rrst=1 sampled at a rclk edge, clear rbin, raddr, rptr, rcount and all synchronizer stages to 0.
REQ-027 SHALL set rempty=1 and ralmost_empty=1 on that same reset edge.
REQ-028 SHALL give reset priority over rinc in every cycle, including a reset asserted mid-burst.
REQ-029 SHALL run normal operation from the first edge after rrst falls.

Configuration
REQ-030 SHALL, with macro RD_UNDERFLOW_EN defined, set runderflow <= 1 on any edge where rinc=1 and rempty=1, holding it until rrst, with reset value 0.
REQ-031 SHALL, with RD_UNDERFLOW_EN undefined, omit the runderflow port and its logic entirely; all other behaviour is identical.

Structure
REQ-032 SHALL place the default parameter constants and a gray2bin function (parametrised by width) in shared package fifo_pkg.
REQ-033 SHALL implement the synchronizer as sub-module sync_nff (parameters WIDTH and STAGES), instantiated once for rd_wptr.
REQ-034 SHALL keep all pointer, flag and count logic within rd_ptr_ctrl.

Verification
REQ-035 SHALL cover reset: with ADDRSIZE=4 and SYNC_STAGES=2, after rrst the outputs are rempty=1, ralmost_empty=1, rcount=0, rptr=0 and raddr=0.
REQ-036 SHALL cover empty-flag latency: driving rd_wptr=5'b00001 with rinc=0 gives rempty=0 and rcount=1 after edge 3, and ralmost_empty stays 1 with AE_THRESH=1.
REQ-037 SHALL cover a burst read: rd_wptr=Gray(16)=5'b11000 followed by 16 reads gives raddr 0..15, final rptr=5'b11000, then rempty=1 and rcount=0.
REQ-038 SHALL cover wrap: after 32 total reads and writes, rptr returns to 5'b00000, with a full-flag compare check at rcount=16 and rempty=0.
REQ-039 SHALL cover underflow: rinc=1 while empty leaves rptr unchanged and, with RD_UNDERFLOW_EN, sets runderflow=1 until rrst.
REQ-040 SHALL cover reset mid-burst: rrst asserted at rcount=7 gives all reset values on the next edge regardless of rinc.
